// File: rtl/aes256_key_store.sv
// aes256_key_store: 15-slot AES-256 round key store fed by an external expander; AES_KEY_STORE_ZEROIZE_EN adds a zeroize input.
module aes256_key_store (
  input  logic         clk,
  input  logic         reset,
`ifdef AES_KEY_STORE_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic [255:0] key_in,
  input  logic         load,
  output logic         kx_start,
  output logic [255:0] kx_key,
  input  logic [127:0] kx_subkey,
  input  logic         kx_valid,
  input  logic         rd_en,
  input  logic         rd_dec,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         rd_valid,
  output logic         rd_err,
  output logic         busy,
  output logic         keys_ready
);
  typedef enum logic [1:0] {IDLE, START, CAPTURE, READY} state_t;
  state_t state, state_nx;
  logic [127:0] slot [15];
  logic [3:0]   idx;
  logic         zero, accept, cap_wr, rd_ok;
  logic [3:0]   eff;
`ifdef AES_KEY_STORE_ZEROIZE_EN
  assign zero = zeroize;
`else
  assign zero = 1'b0;
`endif
  assign accept     = load && (state == IDLE || state == READY);
  assign cap_wr     = state == CAPTURE && kx_valid;
  assign rd_ok      = state == READY && rd_round != 4'd15;
  assign eff        = rd_dec ? 4'd14 - rd_round : rd_round;
  assign kx_start   = state == START;
  assign busy       = state == START || state == CAPTURE;
  assign keys_ready = state == READY;
  always_comb begin
    state_nx = zero                      ? IDLE    :
               accept                    ? START   :
               state == START            ? CAPTURE :
               cap_wr && idx == 4'd14    ? READY   : state;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (reset || zero) begin
      for (int i = 0; i < 15; i++) slot[i] <= '0;
      kx_key   <= '0;
      rd_key   <= '0;
      idx      <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en && rd_ok;
      rd_err   <= rd_en && !rd_ok;
      if (rd_en) rd_key <= rd_ok ? slot[eff] : '0;
      if (accept) begin
        kx_key  <= key_in;
        slot[0] <= key_in[255:128];
        slot[1] <= key_in[127:0];
      end
      if (state == START) idx <= 4'd2;
      else if (cap_wr) begin
        slot[idx] <= kx_subkey;
        idx       <= idx + 4'd1;
      end
    end
  end
endmodule
